// File: rtl/ahb_lite_pkg.sv
// Shared encodings for the AHB-lite compute slave: compute modes, register map,
// response codes and the transfer state machine states.
package ahb_lite_pkg;

    typedef enum logic [1:0] {
        MODE_HALVE    = 2'd0,
        MODE_TRIPLE   = 2'd1,
        MODE_AUTO     = 2'd2,
        MODE_IDENTITY = 2'd3
    } mode_t;

    localparam logic [1:0] REG_MODE   = 2'd0;
    localparam logic [1:0] REG_WAIT   = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_COUNT  = 2'd3;

    localparam logic RESP_OKAY  = 1'b0;
    localparam logic RESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAITING = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/collatz_alu.sv
// Combinational Collatz-step datapath: halve, 3x+1, auto-select by parity, or pass-through.
// ovf flags any nonzero bit lost when 3x+1 is truncated back to WIDTH bits.
module collatz_alu
    import ahb_lite_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  mode_t            mode,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    logic [WIDTH+1:0] tripled;
    logic             useTriple;

    assign tripled = {2'b00, x} + {1'b0, x, 1'b0} + (WIDTH+2)'(1);

    always_comb begin
        useTriple = 1'b0;
        result    = x;
        ovf       = 1'b0;
        case (mode)
            MODE_HALVE:    result = x >> 1;
            MODE_TRIPLE:   useTriple = 1'b1;
            MODE_AUTO:     if (x[0]) useTriple = 1'b1; else result = x >> 1;
            MODE_IDENTITY: result = x;
            default:       result = x;
        endcase
        if (useTriple) begin
            result = tripled[WIDTH-1:0];
            ovf    = |tripled[WIDTH+1:WIDTH];
        end
    end

endmodule

// File: rtl/ahb_lite_compute_slave.sv
// AHB-lite-style slave returning f(waddr) on compute reads, with MODE/WAIT/STATUS/COUNT
// control registers and programmable wait states.
module ahb_lite_compute_slave
    import ahb_lite_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int MAX_WAIT   = 15,
    parameter int RESET_MODE = 0,
    localparam int WW        = $clog2(MAX_WAIT + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             trans,
    input  logic             write,
    input  logic             regsel,
    input  logic [WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    output logic             readyout,
    output logic             resp,
    output logic [WIDTH-1:0] rdata
);

    state_t           state;
    mode_t            modeReg;
    logic [WW-1:0]    waitReg;
    logic [WW-1:0]    waitCnt;
    logic [WIDTH-1:0] countReg;
    logic             ovfReg;

    logic             capWrite, capRegsel;
    logic [WIDTH-1:0] capAddr, capData;

    logic             accept, finish;
    logic             opWrite, opRegsel;
    logic [WIDTH-1:0] opAddr, opData;
    logic [WIDTH-1:0] aluResult;
    logic             aluOvf;
    logic [WW-1:0]    clampedWait;
    logic [WIDTH-1:0] resData;
    logic             resResp;
    logic             isCountWrite;

    assign accept = trans && readyout;
    assign finish = (accept && (waitReg == '0)) || ((state == WAITING) && (waitCnt == '0));

    // Zero-wait transfers complete on the accept edge, so operands come straight from the bus.
    assign opWrite  = accept ? write  : capWrite;
    assign opRegsel = accept ? regsel : capRegsel;
    assign opAddr   = accept ? waddr  : capAddr;
    assign opData   = accept ? wdata  : capData;

    assign clampedWait  = (opData > WIDTH'(MAX_WAIT)) ? WW'(MAX_WAIT) : opData[WW-1:0];
    assign isCountWrite = opRegsel && opWrite && (opAddr[1:0] == REG_COUNT);

    collatz_alu #(.WIDTH(WIDTH)) alu (
        .mode   (modeReg),
        .x      (opAddr),
        .result (aluResult),
        .ovf    (aluOvf)
    );

    always_comb begin
        resData = '0;
        resResp = RESP_OKAY;
        if (!opRegsel) begin
            resData = opWrite ? opData : aluResult;
        end else begin
            case (opAddr[1:0])
                REG_MODE:   resData = opWrite ? WIDTH'(opData[1:0]) : WIDTH'(modeReg);
                REG_WAIT:   resData = opWrite ? WIDTH'(clampedWait) : WIDTH'(waitReg);
                REG_STATUS: begin
                    resData = opWrite ? '0 : WIDTH'(ovfReg);
                    resResp = opWrite ? RESP_ERROR : RESP_OKAY;
                end
                REG_COUNT:  resData = opWrite ? '0 : countReg;
                default:    resData = '0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            readyout  <= 1'b1;
            resp      <= RESP_OKAY;
            rdata     <= '0;
            modeReg   <= mode_t'(2'(RESET_MODE));
            waitReg   <= '0;
            waitCnt   <= '0;
            countReg  <= '0;
            ovfReg    <= 1'b0;
            capWrite  <= 1'b0;
            capRegsel <= 1'b0;
            capAddr   <= '0;
            capData   <= '0;
        end else begin
            if (accept) begin
                capWrite  <= write;
                capRegsel <= regsel;
                capAddr   <= waddr;
                capData   <= wdata;
            end

            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        if (waitReg == '0) begin
                            state <= DONE;
                        end else begin
                            state    <= WAITING;
                            readyout <= 1'b0;
                            waitCnt  <= waitReg - WW'(1);
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                WAITING: begin
                    if (waitCnt == '0) begin
                        state    <= DONE;
                        readyout <= 1'b1;
                    end else begin
                        waitCnt <= waitCnt - WW'(1);
                    end
                end
                default: state <= IDLE;
            endcase

            // Register side effects and counters are committed only at completion.
            if (finish) begin
                rdata <= resData;
                resp  <= resResp;
                if (opRegsel && opWrite) begin
                    if (opAddr[1:0] == REG_MODE) modeReg <= mode_t'(opData[1:0]);
                    if (opAddr[1:0] == REG_WAIT) waitReg <= clampedWait;
                end
                if (isCountWrite) begin
                    countReg <= '0;
                    ovfReg   <= 1'b0;
                end else begin
                    countReg <= countReg + WIDTH'(1);
                    if (!opRegsel && !opWrite && aluOvf) ovfReg <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_lite_compute_slave.sv
// Directed self-checking bench for ahb_lite_compute_slave (WIDTH=8, MAX_WAIT=15, RESET_MODE=0).
module tb_ahb_lite_compute_slave;

    localparam int WIDTH = 8;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             trans = 1'b0;
    logic             write = 1'b0;
    logic             regsel = 1'b0;
    logic [WIDTH-1:0] waddr = '0;
    logic [WIDTH-1:0] wdata = '0;
    logic             readyout;
    logic             resp;
    logic [WIDTH-1:0] rdata;

    int checks = 0;
    int failures = 0;

    logic [WIDTH-1:0] rd;
    logic             rsp;
    int               waits;

    ahb_lite_compute_slave #(.WIDTH(WIDTH), .MAX_WAIT(15), .RESET_MODE(0)) dut (
        .clock    (clock),
        .reset    (reset),
        .trans    (trans),
        .write    (write),
        .regsel   (regsel),
        .waddr    (waddr),
        .wdata    (wdata),
        .readyout (readyout),
        .resp     (resp),
        .rdata    (rdata)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Issues one transfer and returns the completed result plus the number of not-ready cycles seen.
    task automatic applyStimulus(input logic w, input logic rs, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] d, output logic [WIDTH-1:0] rdOut,
                                 output logic rspOut, output int waitOut);
        @(negedge clock);
        trans  = 1'b1;
        write  = w;
        regsel = rs;
        waddr  = a;
        wdata  = d;
        @(posedge clock);
        @(negedge clock);
        trans   = 1'b0;
        waitOut = 0;
        while (!readyout && waitOut < 40) begin
            waitOut++;
            @(negedge clock);
        end
        rdOut  = rdata;
        rspOut = resp;
    endtask

    initial begin
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        checkOutput("reset_readyout", 32'(readyout), 32'd1);
        checkOutput("reset_resp", 32'(resp), 32'd0);
        checkOutput("reset_rdata", 32'(rdata), 32'd0);

        applyStimulus(1'b0, 1'b1, 8'd0, 8'd0, rd, rsp, waits);
        checkOutput("mode_after_reset", 32'(rd), 32'd0);

        applyStimulus(1'b1, 1'b1, 8'd0, 8'd1, rd, rsp, waits);
        checkOutput("write_mode1_echo", 32'(rd), 32'd1);
        applyStimulus(1'b1, 1'b1, 8'd3, 8'h5A, rd, rsp, waits);
        checkOutput("count_write_echo", 32'(rd), 32'd0);

        applyStimulus(1'b0, 1'b0, 8'd5, 8'd0, rd, rsp, waits);
        checkOutput("triple5_rdata", 32'(rd), 32'd16);
        checkOutput("triple5_resp", 32'(rsp), 32'd0);
        checkOutput("triple5_waits", 32'(waits), 32'd0);
        applyStimulus(1'b0, 1'b1, 8'd3, 8'd0, rd, rsp, waits);
        checkOutput("count_after_one", 32'(rd), 32'd1);

        applyStimulus(1'b1, 1'b1, 8'd0, 8'd2, rd, rsp, waits);
        checkOutput("write_mode2_echo", 32'(rd), 32'd2);
        @(negedge clock);
        trans = 1'b1; write = 1'b0; regsel = 1'b0; waddr = 8'd7;
        @(posedge clock);
        @(negedge clock);
        checkOutput("b2b_ready1", 32'(readyout), 32'd1);
        checkOutput("auto7", 32'(rdata), 32'd22);
        waddr = 8'd22;
        @(posedge clock);
        @(negedge clock);
        checkOutput("b2b_ready2", 32'(readyout), 32'd1);
        checkOutput("auto22", 32'(rdata), 32'd11);
        trans = 1'b0;

        applyStimulus(1'b1, 1'b1, 8'd0, 8'd1, rd, rsp, waits);
        applyStimulus(1'b0, 1'b0, 8'h55, 8'd0, rd, rsp, waits);
        checkOutput("triple55_wrap", 32'(rd), 32'h00);
        applyStimulus(1'b0, 1'b1, 8'd2, 8'd0, rd, rsp, waits);
        checkOutput("status_ovf_set", 32'(rd), 32'd1);
        applyStimulus(1'b1, 1'b1, 8'd3, 8'h77, rd, rsp, waits);
        applyStimulus(1'b0, 1'b1, 8'd2, 8'd0, rd, rsp, waits);
        checkOutput("status_ovf_cleared", 32'(rd), 32'd0);

        applyStimulus(1'b0, 1'b0, 8'h55, 8'd0, rd, rsp, waits);
        applyStimulus(1'b1, 1'b1, 8'd2, 8'hFF, rd, rsp, waits);
        checkOutput("status_write_resp", 32'(rsp), 32'd1);
        checkOutput("status_write_rdata", 32'(rd), 32'd0);
        applyStimulus(1'b0, 1'b1, 8'd2, 8'd0, rd, rsp, waits);
        checkOutput("status_after_err", 32'(rd), 32'd1);
        checkOutput("resp_back_okay", 32'(rsp), 32'd0);

        applyStimulus(1'b1, 1'b1, 8'd0, 8'd3, rd, rsp, waits);
        applyStimulus(1'b0, 1'b0, 8'hA5, 8'd0, rd, rsp, waits);
        checkOutput("identity_a5", 32'(rd), 32'hA5);
        applyStimulus(1'b1, 1'b1, 8'd0, 8'd0, rd, rsp, waits);
        applyStimulus(1'b0, 1'b0, 8'hA5, 8'd0, rd, rsp, waits);
        checkOutput("halve_a5", 32'(rd), 32'h52);
        applyStimulus(1'b1, 1'b0, 8'h10, 8'h3C, rd, rsp, waits);
        checkOutput("compute_write_echo", 32'(rd), 32'h3C);

        applyStimulus(1'b1, 1'b1, 8'd1, 8'd3, rd, rsp, waits);
        checkOutput("wait3_echo", 32'(rd), 32'd3);
        applyStimulus(1'b0, 1'b0, 8'h10, 8'd0, rd, rsp, waits);
        checkOutput("wait3_cycles", 32'(waits), 32'd3);
        checkOutput("wait3_rdata", 32'(rd), 32'h08);
        applyStimulus(1'b1, 1'b1, 8'd1, 8'd200, rd, rsp, waits);
        checkOutput("wait_clamp_echo", 32'(rd), 32'd15);
        applyStimulus(1'b0, 1'b1, 8'd1, 8'd0, rd, rsp, waits);
        checkOutput("wait15_cycles", 32'(waits), 32'd15);
        checkOutput("wait_clamp_read", 32'(rd), 32'd15);
        applyStimulus(1'b1, 1'b1, 8'd1, 8'd2, rd, rsp, waits);
        applyStimulus(1'b1, 1'b1, 8'd0, 8'd3, rd, rsp, waits);
        checkOutput("wait2_cycles", 32'(waits), 32'd2);

        // Reset lands during the second wait cycle of an identity read of 0x33.
        @(negedge clock);
        trans = 1'b1; write = 1'b0; regsel = 1'b0; waddr = 8'h33;
        @(posedge clock);
        @(negedge clock);
        trans = 1'b0;
        checkOutput("wait_cycle1_ready", 32'(readyout), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        checkOutput("midreset_ready", 32'(readyout), 32'd1);
        checkOutput("midreset_rdata", 32'(rdata), 32'd0);
        repeat (3) @(negedge clock);
        checkOutput("no_late_completion", 32'(rdata), 32'd0);
        applyStimulus(1'b0, 1'b1, 8'd0, 8'd0, rd, rsp, waits);
        checkOutput("midreset_mode", 32'(rd), 32'd0);
        applyStimulus(1'b0, 1'b1, 8'd1, 8'd0, rd, rsp, waits);
        checkOutput("midreset_wait", 32'(rd), 32'd0);
        checkOutput("midreset_wait_cycles", 32'(waits), 32'd0);
        applyStimulus(1'b0, 1'b1, 8'd3, 8'd0, rd, rsp, waits);
        checkOutput("midreset_count", 32'(rd), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
